// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if: decode-side inputs, WB write-port snoop and EX-side outputs of the ID/EX stage.
interface id_ex_stage_if;
   logic        id_valid;
   logic [4:0]  ReadRegister1, ReadRegister2, id_Rd;
   logic [63:0] ReadData1, ReadData2, id_Imm;
   logic        id_RegWrite, id_MemRead, id_MemWrite, id_ALUSrc;
   logic [2:0]  id_ALUOp;
   logic        wb_RegWrite;
   logic [4:0]  wb_WriteRegister;
   logic [63:0] wb_WriteData;
   logic        hold, flush;
   logic        ex_valid;
   logic [63:0] ex_A, ex_B, ex_Imm;
   logic [4:0]  ex_Rn, ex_Rm, ex_Rd;
   logic        ex_RegWrite, ex_MemRead, ex_MemWrite, ex_ALUSrc;
   logic [2:0]  ex_ALUOp;
   logic        stall_id;
   logic [15:0] bubble_count;
   modport master (
      output id_valid, ReadRegister1, ReadRegister2, ReadData1, ReadData2, id_Rd, id_Imm,
             id_RegWrite, id_MemRead, id_MemWrite, id_ALUSrc, id_ALUOp,
             wb_RegWrite, wb_WriteRegister, wb_WriteData, hold, flush,
      input  ex_valid, ex_A, ex_B, ex_Imm, ex_Rn, ex_Rm, ex_Rd,
             ex_RegWrite, ex_MemRead, ex_MemWrite, ex_ALUSrc, ex_ALUOp, stall_id, bubble_count
   );
   modport slave (
      input  id_valid, ReadRegister1, ReadRegister2, ReadData1, ReadData2, id_Rd, id_Imm,
             id_RegWrite, id_MemRead, id_MemWrite, id_ALUSrc, id_ALUOp,
             wb_RegWrite, wb_WriteRegister, wb_WriteData, hold, flush,
      output ex_valid, ex_A, ex_B, ex_Imm, ex_Rn, ex_Rm, ex_Rd,
             ex_RegWrite, ex_MemRead, ex_MemWrite, ex_ALUSrc, ex_ALUOp, stall_id, bubble_count
   );
endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with WB bypass, load-use bubble insertion and
// a saturating bubble counter.
module id_ex_stage (
   input logic          clk,
   input logic          reset,
   id_ex_stage_if.slave bus
);
   logic        r_valid, r_reg_write, r_mem_read, r_mem_write, r_alu_src;
   logic [2:0]  r_alu_op;
   logic [63:0] r_a, r_b, r_imm;
   logic [4:0]  r_rn, r_rm, r_rd;
   logic [15:0] r_bubble_count;
   logic        w_loaduse, w_kill;
   logic [63:0] w_op_a, w_op_b;
   // X31 reads as zero even if WB happens to target it
   always_comb begin
      w_op_a = (bus.ReadRegister1 == 5'd31) ? 64'd0 :
               (bus.wb_RegWrite && bus.wb_WriteRegister == bus.ReadRegister1) ? bus.wb_WriteData : bus.ReadData1;
      w_op_b = (bus.ReadRegister2 == 5'd31) ? 64'd0 :
               (bus.wb_RegWrite && bus.wb_WriteRegister == bus.ReadRegister2) ? bus.wb_WriteData : bus.ReadData2;
      w_loaduse = r_valid & r_mem_read & (r_rd != 5'd31) & bus.id_valid &
                  ((r_rd == bus.ReadRegister1) | ((r_rd == bus.ReadRegister2) & ~bus.id_ALUSrc));
      w_kill = bus.flush | w_loaduse;
   end
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_valid        <= 1'b0;
         r_reg_write    <= 1'b0;
         r_mem_read     <= 1'b0;
         r_mem_write    <= 1'b0;
         r_alu_src      <= 1'b0;
         r_alu_op       <= 3'd0;
         r_a            <= 64'd0;
         r_b            <= 64'd0;
         r_imm          <= 64'd0;
         r_rn           <= 5'd31;
         r_rm           <= 5'd31;
         r_rd           <= 5'd31;
         r_bubble_count <= 16'd0;
      end else if (!bus.hold) begin
         r_valid     <= bus.id_valid & ~w_kill;
         r_reg_write <= bus.id_RegWrite & bus.id_valid & ~w_kill;
         r_mem_read  <= bus.id_MemRead & bus.id_valid & ~w_kill;
         r_mem_write <= bus.id_MemWrite & bus.id_valid & ~w_kill;
         if (!w_kill) begin
            r_alu_src <= bus.id_ALUSrc & bus.id_valid;
            r_alu_op  <= bus.id_ALUOp & {3{bus.id_valid}};
            r_a       <= w_op_a;
            r_b       <= w_op_b;
            r_imm     <= bus.id_Imm;
            r_rn      <= bus.ReadRegister1;
            r_rm      <= bus.ReadRegister2;
            r_rd      <= bus.id_Rd;
         end
         if (!bus.flush && w_loaduse && r_bubble_count != 16'hFFFF)
            r_bubble_count <= r_bubble_count + 16'd1;
      end
   end
   assign bus.ex_valid     = r_valid;
   assign bus.ex_RegWrite  = r_reg_write;
   assign bus.ex_MemRead   = r_mem_read;
   assign bus.ex_MemWrite  = r_mem_write;
   assign bus.ex_ALUSrc    = r_alu_src;
   assign bus.ex_ALUOp     = r_alu_op;
   assign bus.ex_A         = r_a;
   assign bus.ex_B         = r_b;
   assign bus.ex_Imm       = r_imm;
   assign bus.ex_Rn        = r_rn;
   assign bus.ex_Rm        = r_rm;
   assign bus.ex_Rd        = r_rd;
   assign bus.bubble_count = r_bubble_count;
   assign bus.stall_id     = bus.hold | w_loaduse;
endmodule
